// File: rtl/jtag_pkg.sv
// Shared JTAG-side constants and helpers: synchronizer depth and drop-counter width.
`timescale 1ns/1ps
package jtag_pkg;
  localparam int SYNC_STAGES = 2;
  localparam int OVF_CNT_W   = 8;

  typedef logic [OVF_CNT_W-1:0] ovf_cnt_t;

  function automatic ovf_cnt_t ovf_sat_inc(input ovf_cnt_t cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction
endpackage

// File: rtl/cdc_sync_2ff.sv
// Single-bit level synchronizer, SYNC_STAGES flops deep, cleared by async reset.
`timescale 1ns/1ps
module cdc_sync_2ff
  import jtag_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/usr_reg_cdc.sv
// Toggle req/ack handshake moving a JTAG user register value from TCK to CLK.
// Optional triplicated DO register: define USR_REG_CDC_TMR_EN.
`timescale 1ns/1ps
module usr_reg_cdc
  import jtag_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] DEF_VALUE = '0
) (
  input  logic                 TCK,
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 UPD,
  input  logic [WIDTH-1:0]     PI,
  output logic [WIDTH-1:0]     DO,
  output logic                 DV,
  output logic                 BUSY,
  output logic                 OVF,
  output logic [OVF_CNT_W-1:0] OVF_CNT
);
  // TCK domain
  logic             r_req;
  logic [WIDTH-1:0] r_hold;
  logic             r_ovf;
  ovf_cnt_t         r_ovf_cnt;
  logic             w_ack_s;
  logic             w_busy;

  // CLK domain
  logic             r_ack;
  logic             r_req_d;
  logic             r_dv;
  logic             w_req_s;
  logic             w_req_edge;

  // BUSY is a pure XOR of flops, so it cannot glitch on UPD or PI.
  assign w_busy = r_req ^ w_ack_s;

  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      r_req     <= 1'b0;
      r_hold    <= DEF_VALUE;
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (UPD) begin
      if (!w_busy) begin
        r_hold <= PI;
        r_req  <= ~r_req;
      end else begin
        r_ovf     <= 1'b1;
        r_ovf_cnt <= ovf_sat_inc(r_ovf_cnt);
      end
    end
  end

  cdc_sync_2ff u_req_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (r_req),
    .o_q   (w_req_s)
  );

  cdc_sync_2ff u_ack_sync (
    .i_clk (TCK),
    .i_rst (RST),
    .i_d   (r_ack),
    .o_q   (w_ack_s)
  );

  assign w_req_edge = w_req_s ^ r_req_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_req_d <= 1'b0;
      r_ack   <= 1'b0;
      r_dv    <= 1'b0;
    end else begin
      r_req_d <= w_req_s;
      r_dv    <= w_req_edge;
      if (w_req_edge) r_ack <= ~r_ack;
    end
  end

`ifdef USR_REG_CDC_TMR_EN
  logic [WIDTH-1:0] r_do_a;
  logic [WIDTH-1:0] r_do_b;
  logic [WIDTH-1:0] r_do_c;
  logic [WIDTH-1:0] w_do_vote;

  function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign w_do_vote = maj3(r_do_a, r_do_b, r_do_c);

  // Idle cycles rewrite every copy from the vote, scrubbing single upsets.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_do_a <= DEF_VALUE;
      r_do_b <= DEF_VALUE;
      r_do_c <= DEF_VALUE;
    end else if (w_req_edge) begin
      r_do_a <= r_hold;
      r_do_b <= r_hold;
      r_do_c <= r_hold;
    end else begin
      r_do_a <= w_do_vote;
      r_do_b <= w_do_vote;
      r_do_c <= w_do_vote;
    end
  end

  assign DO = w_do_vote;
`else
  logic [WIDTH-1:0] r_do;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             r_do <= DEF_VALUE;
    else if (w_req_edge) r_do <= r_hold;
  end

  assign DO = r_do;
`endif

  assign DV      = r_dv;
  assign BUSY    = w_busy;
  assign OVF     = r_ovf;
  assign OVF_CNT = r_ovf_cnt;
endmodule

// File: tb/tb_usr_reg_cdc.sv
// Directed bench for usr_reg_cdc: reset, single transfer, overflow, back-to-back,
// reset mid-transfer, counter saturation, and the TMR scrub when USR_REG_CDC_TMR_EN is set.
`timescale 1ns/1ps
module tb_usr_reg_cdc;
  localparam int         WIDTH = 8;
  localparam logic [7:0] DEF   = 8'h3C;

  logic       TCK = 1'b0;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       UPD = 1'b0;
  logic [7:0] PI  = 8'h00;
  logic       clk_en = 1'b1;
  logic [7:0] DO;
  logic       DV;
  logic       BUSY;
  logic       OVF;
  logic [7:0] OVF_CNT;

  int total = 0;
  int bad   = 0;
  int dv_seen = 0;

  usr_reg_cdc #(.WIDTH(WIDTH), .DEF_VALUE(DEF)) dut (
    .TCK(TCK), .CLK(CLK), .RST(RST), .UPD(UPD), .PI(PI),
    .DO(DO), .DV(DV), .BUSY(BUSY), .OVF(OVF), .OVF_CNT(OVF_CNT)
  );

  // TCK 20 MHz, CLK 40 MHz; CLK rises 12.5 ns after every TCK rise.
  always #25 TCK = ~TCK;
  always #12.5 if (clk_en) CLK = ~CLK;

  always @(posedge CLK) if (DV === 1'b1) dv_seen <= dv_seen + 1;

  task automatic do_reset();
    @(negedge TCK);
    UPD = 1'b0;
    RST = 1'b1;
    #60;
    RST = 1'b0;
    @(negedge TCK);
  endtask

  task automatic test_reset();
    #5 RST = 1'b1;
    #5;
    total++; if (DO !== DEF)      begin bad++; $display("FAIL reset_DO got=%h want=%h", DO, DEF); end
    total++; if (DV !== 1'b0)     begin bad++; $display("FAIL reset_DV got=%b want=0", DV); end
    total++; if (BUSY !== 1'b0)   begin bad++; $display("FAIL reset_BUSY got=%b want=0", BUSY); end
    total++; if (OVF !== 1'b0)    begin bad++; $display("FAIL reset_OVF got=%b want=0", OVF); end
    total++; if (OVF_CNT !== 8'd0) begin bad++; $display("FAIL reset_OVF_CNT got=%0d want=0", OVF_CNT); end
    @(negedge TCK);
    RST = 1'b0;
    @(negedge TCK);
  endtask

  task automatic test_single();
    int dv_cnt = 0;
    int dv_first = 0;
    int busy_cnt = 0;
    do_reset();
    UPD = 1'b1; PI = 8'hA5;
    @(posedge TCK);
    #1 UPD = 1'b0; PI = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      @(posedge CLK); #1;
      if (DV === 1'b1) begin
        dv_cnt++;
        if (dv_first == 0) dv_first = i;
      end
      if (BUSY === 1'b1) busy_cnt++;
    end
    total++; if (dv_first != 3)   begin bad++; $display("FAIL single_dv_edge got=%0d want=3", dv_first); end
    total++; if (dv_cnt != 1)     begin bad++; $display("FAIL single_dv_count got=%0d want=1", dv_cnt); end
    total++; if (DO !== 8'hA5)    begin bad++; $display("FAIL single_DO got=%h want=a5", DO); end
    total++; if (busy_cnt != 6)   begin bad++; $display("FAIL single_busy_len got=%0d want=6", busy_cnt); end
    total++; if (BUSY !== 1'b0)   begin bad++; $display("FAIL single_busy_end got=%b want=0", BUSY); end
  endtask

  task automatic test_overflow();
    int d0;
    do_reset();
    d0 = dv_seen;
    UPD = 1'b1; PI = 8'h11;
    @(negedge TCK) PI = 8'h22;
    @(negedge TCK) PI = 8'h33;
    @(negedge TCK) UPD = 1'b0;
    repeat (12) @(negedge TCK);
    total++; if (dv_seen - d0 != 1) begin bad++; $display("FAIL ovf_dv_count got=%0d want=1", dv_seen - d0); end
    total++; if (DO !== 8'h11)      begin bad++; $display("FAIL ovf_DO got=%h want=11", DO); end
    total++; if (OVF !== 1'b1)      begin bad++; $display("FAIL ovf_flag got=%b want=1", OVF); end
    total++; if (OVF_CNT !== 8'd2)  begin bad++; $display("FAIL ovf_cnt got=%0d want=2", OVF_CNT); end
  endtask

  task automatic test_back_to_back();
    int d0;
    do_reset();
    d0 = dv_seen;
    UPD = 1'b1; PI = 8'h66;
    for (int i = 0; i < 10; i++) begin
      @(negedge TCK);
      if (BUSY === 1'b1) PI = 8'h77;
      else begin
        PI = 8'h88;
        break;
      end
    end
    @(negedge TCK) UPD = 1'b0;
    repeat (12) @(negedge TCK);
    total++; if (OVF_CNT !== 8'd3)  begin bad++; $display("FAIL b2b_drops got=%0d want=3", OVF_CNT); end
    total++; if (DO !== 8'h88)      begin bad++; $display("FAIL b2b_DO got=%h want=88", DO); end
    total++; if (dv_seen - d0 != 2) begin bad++; $display("FAIL b2b_dv_count got=%0d want=2", dv_seen - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    do_reset();
    d0 = dv_seen;
    UPD = 1'b1; PI = 8'hC3;
    @(posedge TCK);
    #1 UPD = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #30 RST = 1'b0;
    repeat (12) @(negedge TCK);
    total++; if (dv_seen - d0 != 0) begin bad++; $display("FAIL mid_dv_count got=%0d want=0", dv_seen - d0); end
    total++; if (DO !== DEF)        begin bad++; $display("FAIL mid_DO got=%h want=%h", DO, DEF); end
    total++; if (BUSY !== 1'b0)     begin bad++; $display("FAIL mid_BUSY got=%b want=0", BUSY); end
  endtask

  task automatic test_saturation();
    int d0;
    do_reset();
    @(negedge CLK) clk_en = 1'b0;
    d0 = dv_seen;
    @(negedge TCK);
    UPD = 1'b1; PI = 8'h5E;
    @(negedge TCK) PI = 8'hFF;
    repeat (254) @(negedge TCK);
    total++; if (OVF_CNT !== 8'd254) begin bad++; $display("FAIL sat_cnt_254 got=%0d want=254", OVF_CNT); end
    repeat (46) @(negedge TCK);
    UPD = 1'b0;
    total++; if (OVF_CNT !== 8'd255) begin bad++; $display("FAIL sat_cnt_255 got=%0d want=255", OVF_CNT); end
    total++; if (OVF !== 1'b1)       begin bad++; $display("FAIL sat_OVF got=%b want=1", OVF); end
    clk_en = 1'b1;
    repeat (12) @(negedge TCK);
    total++; if (DO !== 8'h5E)       begin bad++; $display("FAIL sat_DO got=%h want=5e", DO); end
    total++; if (dv_seen - d0 != 1)  begin bad++; $display("FAIL sat_dv_count got=%0d want=1", dv_seen - d0); end
  endtask

`ifdef USR_REG_CDC_TMR_EN
  task automatic test_tmr();
    @(negedge CLK);
    force dut.r_do_a = 8'h5F;
    #1;
    total++; if (DO !== 8'h5E) begin bad++; $display("FAIL tmr_vote got=%h want=5e", DO); end
    release dut.r_do_a;
    @(posedge CLK); #1;
    total++; if (dut.r_do_a !== 8'h5E) begin bad++; $display("FAIL tmr_scrub got=%h want=5e", dut.r_do_a); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
`ifdef USR_REG_CDC_TMR_EN
    test_tmr();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
